// File: rtl/mc_ctrl_fsm.sv
// Multicycle main controller: sequences each instruction through
// fetch/decode/execute/memory/writeback and decodes per-state datapath
// selects plus unconditioned write strobes for the condition logic.
module mc_ctrl_fsm (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] instr,
   output logic        pcs,
   output logic        reg_w,
   output logic        mem_w,
   output logic [1:0]  flag_w,
   output logic [3:0]  cond,
   output logic        next_pc,
   output logic        ir_write,
   output logic        adr_src,
   output logic        alu_src_a,
   output logic [1:0]  alu_src_b,
   output logic [1:0]  alu_control,
   output logic [1:0]  result_src,
   output logic [1:0]  imm_src,
   output logic        retire,
   output logic [3:0]  state
);

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_MEMADR = 4'd2,
      S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,
      S_MEMWR  = 4'd5,
      S_EXECR  = 4'd6,
      S_EXECI  = 4'd7,
      S_ALUWB  = 4'd8,
      S_BRANCH = 4'd9
   } state_t;

   state_t     state_q, state_d;
   // Low until the first edge after reset release, so FETCH strobes only
   // start in the cycle following the release and are zero during reset.
   logic       active_q;

   logic [1:0] op;
   logic [5:0] funct;
   logic [3:0] cmd;
   logic [3:0] rd;
   logic       s_bit;
   logic       unused_instr;

   logic [1:0] dp_alu_ctl;
   logic       dp_no_write;
   logic       dp_arith;
   logic       dp_valid;

   assign op           = instr[27:26];
   assign funct        = instr[25:20];
   assign cmd          = funct[4:1];
   assign s_bit        = funct[0];
   assign rd           = instr[15:12];
   assign unused_instr = ^{instr[19:16], instr[11:0]};

   assign cond    = instr[31:28];
   assign imm_src = op;
   assign state   = state_q;

   // Data-processing command decode: ALU op, write suppression, flag class.
   always_comb begin
      dp_alu_ctl  = 2'b00;
      dp_no_write = 1'b1;
      dp_arith    = 1'b0;
      dp_valid    = 1'b0;
      case (cmd)
         4'b0100: begin dp_alu_ctl = 2'b00; dp_no_write = 1'b0; dp_arith = 1'b1; dp_valid = 1'b1; end
         4'b0010: begin dp_alu_ctl = 2'b01; dp_no_write = 1'b0; dp_arith = 1'b1; dp_valid = 1'b1; end
         4'b0000: begin dp_alu_ctl = 2'b10; dp_no_write = 1'b0; dp_valid = 1'b1; end
         4'b1100: begin dp_alu_ctl = 2'b11; dp_no_write = 1'b0; dp_valid = 1'b1; end
         4'b1010: begin dp_alu_ctl = 2'b01; dp_no_write = 1'b1; dp_arith = 1'b1; dp_valid = 1'b1; end
         default: begin dp_alu_ctl = 2'b00; dp_no_write = 1'b1; dp_arith = 1'b0; dp_valid = 1'b0; end
      endcase
   end

   // Next-state selection from the current state and instruction fields.
   always_comb begin
      state_d = S_FETCH;
      case (state_q)
         S_FETCH:  state_d = S_DECODE;
         S_DECODE: begin
            case (op)
               2'b01:   state_d = S_MEMADR;
               2'b00:   state_d = funct[5] ? S_EXECI : S_EXECR;
               2'b10:   state_d = S_BRANCH;
               default: state_d = S_FETCH;
            endcase
         end
         S_MEMADR: state_d = funct[0] ? S_MEMRD : S_MEMWR;
         S_MEMRD:  state_d = S_MEMWB;
         S_EXECR:  state_d = S_ALUWB;
         S_EXECI:  state_d = S_ALUWB;
         default:  state_d = S_FETCH;
      endcase
   end

   // State register; reset parks in FETCH and aborts any instruction in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_FETCH;
         active_q <= 1'b0;
      end else begin
         active_q <= 1'b1;
         state_q  <= active_q ? state_d : S_FETCH;
      end
   end

   // Moore output decode; everything is held at zero until the FSM is active.
   always_comb begin
      pcs         = 1'b0;
      reg_w       = 1'b0;
      mem_w       = 1'b0;
      flag_w      = 2'b00;
      next_pc     = 1'b0;
      ir_write    = 1'b0;
      adr_src     = 1'b0;
      alu_src_a   = 1'b0;
      alu_src_b   = 2'b00;
      alu_control = 2'b00;
      result_src  = 2'b00;
      retire      = 1'b0;
      if (active_q) begin
         case (state_q)
            S_FETCH: begin
               ir_write   = 1'b1;
               next_pc    = 1'b1;
               alu_src_a  = 1'b1;
               alu_src_b  = 2'b10;
               result_src = 2'b10;
            end
            S_DECODE: begin
               alu_src_a  = 1'b1;
               alu_src_b  = 2'b10;
               result_src = 2'b10;
               retire     = (op == 2'b11);
            end
            S_MEMADR: alu_src_b = 2'b01;
            S_MEMRD:  adr_src = 1'b1;
            S_MEMWR: begin
               adr_src = 1'b1;
               mem_w   = 1'b1;
               retire  = 1'b1;
            end
            S_MEMWB: begin
               result_src = 2'b01;
               reg_w      = 1'b1;
               pcs        = (rd == 4'hF);
               retire     = 1'b1;
            end
            S_EXECR: alu_control = dp_alu_ctl;
            S_EXECI: begin
               alu_src_b   = 2'b01;
               alu_control = dp_alu_ctl;
            end
            S_ALUWB: begin
               alu_control = dp_alu_ctl;
               reg_w       = ~dp_no_write;
               pcs         = ~dp_no_write & (rd == 4'hF);
               flag_w      = dp_valid ? {s_bit, s_bit & dp_arith} : 2'b00;
               retire      = 1'b1;
            end
            S_BRANCH: begin
               alu_src_b  = 2'b01;
               result_src = 2'b10;
               pcs        = 1'b1;
               retire     = 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Scoreboard bench for mc_ctrl_fsm: each instruction pushes its expected
// per-cycle state/output records, which are popped and compared each cycle.
module tb_mc_ctrl_fsm;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] instr = 32'h0;
   logic        pcs, reg_w, mem_w, next_pc, ir_write, adr_src, alu_src_a, retire;
   logic [1:0]  flag_w, alu_src_b, alu_control, result_src, imm_src;
   logic [3:0]  cond, state;

   int n_cmp = 0;
   int n_err = 0;

   typedef struct packed {
      logic [3:0]  st;
      logic [15:0] bus;
   } exp_t;
   exp_t exp_q[$];

   wire [15:0] out_bus = {pcs, reg_w, mem_w, flag_w, next_pc, ir_write, adr_src,
                          alu_src_a, alu_src_b, alu_control, result_src, retire};

   mc_ctrl_fsm dut (
      .clk(clk), .rst_n(rst_n), .instr(instr),
      .pcs(pcs), .reg_w(reg_w), .mem_w(mem_w), .flag_w(flag_w), .cond(cond),
      .next_pc(next_pc), .ir_write(ir_write), .adr_src(adr_src),
      .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_control(alu_control),
      .result_src(result_src), .imm_src(imm_src), .retire(retire), .state(state)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: run exceeded time limit, cmp=%0d err=%0d", n_cmp, n_err);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic push(input logic [3:0] st, input logic p, input logic rw, input logic mw,
                       input logic [1:0] fw, input logic np, input logic irw, input logic adr,
                       input logic sa, input logic [1:0] sb, input logic [1:0] ctl,
                       input logic [1:0] rs, input logic ret);
      exp_t e;
      e.st  = st;
      e.bus = {p, rw, mw, fw, np, irw, adr, sa, sb, ctl, rs, ret};
      exp_q.push_back(e);
   endtask

   // Reference sequence built from the state/output tables of the controller.
   task automatic push_instr(input logic [31:0] ins);
      logic [1:0] op;
      logic [5:0] fn;
      logic       rd15, wr, arith, known;
      logic [1:0] ctl, fw;
      op   = ins[27:26];
      fn   = ins[25:20];
      rd15 = (ins[15:12] == 4'hF);
      push(4'd0, 0, 0, 0, 2'b00, 1, 1, 0, 1, 2'b10, 2'b00, 2'b10, 0);
      push(4'd1, 0, 0, 0, 2'b00, 0, 0, 0, 1, 2'b10, 2'b00, 2'b10, op == 2'b11);
      case (op)
         2'b01: begin
            push(4'd2, 0, 0, 0, 2'b00, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 0);
            if (fn[0]) begin
               push(4'd3, 0, 0, 0, 2'b00, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 0);
               push(4'd4, rd15, 1, 0, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 2'b01, 1);
            end else begin
               push(4'd5, 0, 0, 1, 2'b00, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 1);
            end
         end
         2'b00: begin
            known = 1; wr = 1; arith = 0; ctl = 2'b00;
            case (fn[4:1])
               4'b0100: begin ctl = 2'b00; arith = 1; end
               4'b0010: begin ctl = 2'b01; arith = 1; end
               4'b0000: ctl = 2'b10;
               4'b1100: ctl = 2'b11;
               4'b1010: begin ctl = 2'b01; arith = 1; wr = 0; end
               default: begin known = 0; wr = 0; end
            endcase
            fw = known ? {fn[0], fn[0] & arith} : 2'b00;
            if (fn[5]) push(4'd7, 0, 0, 0, 2'b00, 0, 0, 0, 0, 2'b01, ctl, 2'b00, 0);
            else       push(4'd6, 0, 0, 0, 2'b00, 0, 0, 0, 0, 2'b00, ctl, 2'b00, 0);
            push(4'd8, wr & rd15, wr, 0, fw, 0, 0, 0, 0, 2'b00, ctl, 2'b00, 1);
         end
         2'b10: push(4'd9, 1, 0, 0, 2'b00, 0, 0, 0, 0, 2'b01, 2'b00, 2'b10, 1);
         default: ;
      endcase
   endtask

   task automatic run_cycles(input int n);
      exp_t e;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (exp_q.size() == 0) begin
            chk("queue_underflow", 32'd1, 32'd0);
         end else begin
            e = exp_q.pop_front();
            chk($sformatf("state[%h]", instr), {28'd0, state}, {28'd0, e.st});
            chk($sformatf("outs[%h] st%0d", instr, e.st), {16'd0, out_bus}, {16'd0, e.bus});
            chk("cond", {28'd0, cond}, {28'd0, instr[31:28]});
            chk("imm_src", {30'd0, imm_src}, {30'd0, instr[27:26]});
         end
      end
   endtask

   task automatic run_instr(input logic [31:0] ins);
      @(posedge clk);
      #1 instr = ins;
      push_instr(ins);
      run_cycles(exp_q.size());
      $display("instr %h done, cmp=%0d err=%0d", ins, n_cmp, n_err);
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_state"}, {28'd0, state}, 32'd0);
      chk({tag, "_outs"}, {16'd0, out_bus}, 32'd0);
   endtask

   logic [31:0] prog [0:10];

   initial begin
      prog[0]  = 32'hE5912004; // LDR
      prog[1]  = 32'hE5812004; // STR
      prog[2]  = 32'hE0912003; // ADDS
      prog[3]  = 32'hE1510002; // CMP
      prog[4]  = 32'hE0112003; // ANDS
      prog[5]  = 32'h0A000002; // B
      prog[6]  = 32'hEC000000; // undefined op
      prog[7]  = 32'hE3812001; // ORR immediate
      prog[8]  = 32'hE080F002; // ADD to PC
      prog[9]  = 32'hE591F004; // LDR to PC
      prog[10] = 32'hE0312003; // unsupported cmd, S set

      repeat (2) @(posedge clk);
      @(negedge clk);
      chk_idle("in_reset");
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk_idle("release_cycle");

      for (int i = 0; i < 11; i++) run_instr(prog[i]);

      // Abort an LDR in MEMRD with a one-cycle reset pulse.
      @(posedge clk);
      #1 instr = 32'hE5912004;
      push_instr(instr);
      run_cycles(4);
      #2 rst_n = 1'b0;
      #1 chk_idle("abort_memrd");
      exp_q.delete();
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk_idle("abort_release");
      $display("reset abort checked, cmp=%0d err=%0d", n_cmp, n_err);

      run_instr(32'hE0512003); // SUBS
      run_instr(32'hE5912004); // LDR after abort
      chk("queue_empty", exp_q.size(), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/mc_ctrl_fsm.md
# mc_ctrl_fsm

Multicycle main controller that decodes the instruction-register fields and sequences each instruction through fetch, decode, execute, memory and writeback states. It produces the per-cycle datapath selects and the unconditioned write strobes (`pcs`, `reg_w`, `mem_w`, `flag_w`, `cond`) consumed by `cond_logic`, which applies the condition check. Placed between the instruction register and `cond_logic`/datapath in the multicycle core.

## Interface
- No parameters.
- `clk` input 1: sole clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `instr` input 32: instruction register contents; bits [31:28] cond, [27:26] op, [25:20] funct, [15:12] rd; stable from the cycle after FETCH.
- `pcs` output 1: PC-write request (branch, or register write with rd=15), unconditioned.
- `reg_w` output 1: register-file write request, unconditioned.
- `mem_w` output 1: data-memory write request, unconditioned.
- `flag_w` output 2: [1] update N,Z; [0] update C,V.
- `cond` output 4: instr[31:28] passthrough.
- `next_pc` output 1: unconditional PC update (fetch increment).
- `ir_write` output 1: load instruction register.
- `adr_src` output 1: 0 = PC, 1 = ALU result register.
- `alu_src_a` output 1: 0 = register A, 1 = PC.
- `alu_src_b` output 2: 00 register B, 01 extended immediate, 10 constant 4.
- `alu_control` output 2: 00 ADD, 01 SUB, 10 AND, 11 ORR.
- `result_src` output 2: 00 ALU-out register, 01 read data, 10 ALU direct.
- `imm_src` output 2: equals op.
- `retire` output 1: high in the last cycle of each instruction.
- `state` output 4: current state encoding, for debug.

## Operation
- States (encoding): FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXECR 6, EXECI 7, ALUWB 8, BRANCH 9. Encodings 10–15 go to FETCH on the next edge.
- Transitions:
  - FETCH→DECODE.
  - DECODE→MEMADR for op=01.
  - DECODE→EXECR for op=00 with funct[5]=0.
  - DECODE→EXECI for op=00 with funct[5]=1.
  - DECODE→BRANCH for op=10.
  - DECODE→FETCH for op=11 (undefined).
  - MEMADR→MEMRD if funct[0]=1, else MEMWR.
  - MEMRD→MEMWB.
  - EXECR/EXECI→ALUWB.
  - MEMWB, MEMWR, ALUWB, BRANCH→FETCH.
- Moore outputs per state; every output not listed is 0:
  - FETCH: ir_write=1, next_pc=1, alu_src_a=1, alu_src_b=10, result_src=10.
  - DECODE: alu_src_a=1, alu_src_b=10, result_src=10. With op=11, retire=1 here.
  - MEMADR: alu_src_b=01, ADD.
  - MEMRD / MEMWR: adr_src=1; MEMWR also mem_w=1 and retire=1.
  - MEMWB: result_src=01, reg_w=1, retire=1.
  - EXECR: alu_src_b=00. EXECI: alu_src_b=01. Both use the decoded ALU op.
  - ALUWB: reg_w=1 unless no-write, plus decoded flag_w, retire=1.
  - BRANCH: alu_src_b=01, ADD, result_src=10, pcs=1, retire=1.
- DP decode of funct[4:1]:
  - 0100 ADD; 0010 SUB; 0000 AND; 1100 ORR; 1010 CMP (SUB, no-write).
  - Any other cmd: ADD with no-write, flag_w=00.
- flag_w = {S, S & (ADD|SUB|CMP)}, where S=funct[0]. It is nonzero only in ALUWB.
- pcs additionally = reg_w & (rd==4'hF) in MEMWB/ALUWB.
- cond and imm_src are combinational from instr in all states.

## Timing
- While rst_n=0: state=FETCH, and every output except cond/imm_src is forced to 0.
- The first FETCH strobes appear in the cycle after rst_n rises.
- Reset asserted mid-instruction aborts it immediately: no strobe may persist, and no partial writeback occurs.
- Latency, FETCH through retire inclusive:
  - LDR 5 cycles.
  - STR 4.
  - DP 4.
  - B 3.
  - Undefined 2.
- Outputs are purely state/instr decoded. Glitch-free strobes rely on instr being stable after FETCH.
- Exactly one retire pulse per instruction. There is no back-pressure.

## Test plan
- Reset mid-MEMRD (rst_n low 1 cycle) → state=0 and all strobes 0 immediately. After release: FETCH with ir_write=1, next_pc=1.
- LDR instr=32'hE5912004 → states 0,1,2,3,4. MEMWB: reg_w=1, result_src=01, retire=1, pcs=0.
- STR 32'hE5812004 → states 0,1,2,5. mem_w=1 only in state 5; reg_w never asserts.
- ADDS 32'hE0912003 → states 0,1,6,8. ALUWB: reg_w=1, flag_w=11, alu_control=00.
- CMP 32'hE1510002 → ALUWB: reg_w=0, flag_w=11, alu_control=01. ANDS → flag_w=10, alu_control=10.
- B 32'h0A000002 → states 0,1,9. BRANCH: pcs=1, cond=0000, retire=1. Undefined op=11 → 0,1 with retire=1 in DECODE, then back to 0.
